scancode_player: RTL

- Buffered scan-code stimulus engine. Queues PS/2 keyboard scan codes and wait commands, then replays them as a timed stream on the step_sequencer data/strobe pair (sim_data / sim_data_en).
- Generalises the hand-written keystroke sequences used to drive the sequencer in simulation. Adds:
  - parametrised queue depth and inter-code gap
  - embedded delay commands
  - pause/resume
- Synthesizable, so it can also run on-board for scripted demos.

---
 rtl/scanplay_pkg.sv | 21 ++
 rtl/scanplay_fifo.sv | 48 ++++
 rtl/scancode_player.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/scanplay_pkg.sv
// Shared types and constants for the scan-code player.
package scanplay_pkg;

  typedef enum logic [2:0] {
    IDLE, DECODE, EMIT, GAP, WAIT, BRK_F0, BRK_CODE
  } state_t;

  // Where a finished gap leads when make/break playback is built in.
  typedef enum logic [1:0] {PH_F0, PH_CODE, PH_DONE} brk_ph_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam int         WAIT_FLAG = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scanplay_fifo.sv
// Synchronous show-ahead FIFO with occupancy and sticky overflow.
module scanplay_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = 9,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_data,
  input  logic          rd_en,
  output logic [CW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [LW-1:0] level
);
  logic [CW-1:0] mem [DEPTH];
  logic [LW-1:0] wptr, rptr;
  logic          push;

  // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
  assign push     = wr_en && (!full || rd_en);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign level    = wptr - rptr;
  assign rd_data  = mem[rptr[AW-1:0]];

  // Storage has no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + LW'(1);
      if (rd_en) rptr <= rptr + LW'(1);
      if (wr_en && full && !rd_en) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/scancode_player.sv
// Buffered scan-code replay engine: queues codes/wait commands and emits a
// timed strobe stream. Define SCANPLAY_BREAK_EN to append F0+code break
// sequences after every make code.
module scancode_player
  import scanplay_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 4,
  parameter int WAIT_UNIT  = 500,
  parameter int CW         = 9,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic          CLOCK_50,
  input  logic          KEY0,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_data,
  input  logic          run,
  output logic [CW-1:0] out_data,
  output logic          out_en,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic          overflow,
  output logic [LW-1:0] level
);
  localparam int CNTW = $clog2(max2(GAP_CYCLES, 255 * WAIT_UNIT) + 1);

  state_t          state, state_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic [CW-1:0]   hold, fifo_q;
  logic            pop, stb;
  logic [CW-1:0]   stb_data;
  logic [CW-1:0]   code;

  assign code = {{(CW-8){1'b0}}, hold[7:0]};
  assign busy = (state != IDLE);

  scanplay_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk      (CLOCK_50),
    .rst_n    (KEY0),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_q),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .level    (level)
  );

`ifdef SCANPLAY_BREAK_EN
  brk_ph_t ph, ph_nx;

  // Break-sequence phase register.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) ph <= PH_DONE;
    else       ph <= ph_nx;
  end
`endif

  // State, counter, holding register and registered strobe output.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state    <= IDLE;
      cnt      <= '0;
      hold     <= '0;
      out_en   <= 1'b0;
      out_data <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      out_en <= stb;
      if (pop) hold     <= fifo_q;
      if (stb) out_data <= stb_data;
    end
  end

  // Next state; strobes are decided on entry so out_en is high during the emit state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    stb      = 1'b0;
    stb_data = code;
`ifdef SCANPLAY_BREAK_EN
    ph_nx    = ph;
`endif
    case (state)
      IDLE: if (run && !empty) begin
        pop      = 1'b1;
        state_nx = DECODE;
      end
      DECODE: begin
        if (!hold[WAIT_FLAG]) begin
          state_nx = EMIT;
          stb      = 1'b1;
        end else if (hold[7:0] != 8'd0) begin
          cnt_nx   = CNTW'(hold[7:0]) * CNTW'(WAIT_UNIT) - CNTW'(1);
          state_nx = WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      EMIT: begin
        cnt_nx   = CNTW'(GAP_CYCLES - 1);
        state_nx = GAP;
`ifdef SCANPLAY_BREAK_EN
        // Prefix bytes are replayed verbatim; no break is synthesised for them.
        ph_nx = (hold[7:0] == SC_BREAK || hold[7:0] == SC_EXT) ? PH_DONE : PH_F0;
`endif
      end
      GAP: begin
        if (cnt == '0) begin
          state_nx = IDLE;
`ifdef SCANPLAY_BREAK_EN
          if (ph == PH_F0) begin
            state_nx = BRK_F0;
            stb      = 1'b1;
            stb_data = {{(CW-8){1'b0}}, SC_BREAK};
          end else if (ph == PH_CODE) begin
            state_nx = BRK_CODE;
            stb      = 1'b1;
          end
`endif
        end else begin
          cnt_nx = cnt - CNTW'(1);
        end
      end
      WAIT: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - CNTW'(1);
      end
`ifdef SCANPLAY_BREAK_EN
      BRK_F0: begin
        cnt_nx   = CNTW'(GAP_CYCLES - 1);
        state_nx = GAP;
        ph_nx    = PH_CODE;
      end
      BRK_CODE: begin
        cnt_nx   = CNTW'(GAP_CYCLES - 1);
        state_nx = GAP;
        ph_nx    = PH_DONE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

endmodule
